// File: rtl/imm_ctrl.sv
// imm_ctrl -- decode-stage immediate controller for the 16-bit pipeline.
//
// Drives the shared Extender from the decoder's immediate class and registers
// the 16-bit immediate into the ID/EX boundary. A one-instruction prefix
// supplies the upper byte of a full 16-bit constant for the next
// immediate-using instruction.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   in_valid       decoder presents an instruction this cycle
//   imm_field[7:0] raw immediate bits, instr[7:0]
//   imm_kind[1:0]  00 none, 01 imm5 unsigned, 10 imm5 signed, 11 imm8 zero-ext
//   is_prefix      instruction is an immediate prefix (imm_field = upper byte)
//   stall          hold the ID stage
//   flush          squash the ID stage (wins over stall and in_valid)
//   ext_op         Extender.ExtOp (combinational from imm_kind)
//   ext_place      Extender.ExtPlace (combinational from imm_kind)
//   imm_q[15:0]    registered immediate for EX
//   imm_valid_q    imm_q belongs to a valid, immediate-using instruction
//   prefix_used_q  imm_q was formed from a prefix
//   prefix_pending a prefix byte is waiting for its consumer
//   prefix_drop    one-cycle pulse when a pending prefix is discarded

// Immediate extender. ExtPlace selects the 8-bit zero-extended form; otherwise
// the low 5 bits are zero- or sign-extended according to ExtOp.
module Extender (
  input  logic [7:0]  in,
  input  logic        ExtOp,
  input  logic        ExtPlace,
  output logic [15:0] out
);
  assign out[4:0] = in[4:0];

  // Bits 7:5 come from the field only in the imm8 form.
  for (genvar gi = 5; gi < 8; gi++) begin : gMid
    assign out[gi] = ExtPlace ? in[gi] : (ExtOp & in[4]);
  end

  // The upper byte is only ever populated by sign extension of imm5.
  for (genvar gi = 8; gi < 16; gi++) begin : gHigh
    assign out[gi] = ~ExtPlace & ExtOp & in[4];
  end
endmodule

module imm_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  imm_field,
  input  logic [1:0]  imm_kind,
  input  logic        is_prefix,
  input  logic        stall,
  input  logic        flush,
  output logic        ext_op,
  output logic        ext_place,
  output logic [15:0] imm_q,
  output logic        imm_valid_q,
  output logic        prefix_used_q,
  output logic        prefix_pending,
  output logic        prefix_drop
);
  typedef enum logic {IDLE = 1'b0, PREFIXED = 1'b1} stateT;

  stateT       stateReg, stateNext;
  logic [7:0]  upperReg, upperNext;
  logic [15:0] immReg, immNext;
  logic        validReg, validNext;
  logic        usedReg, usedNext;
  logic        dropReg, dropNext;
  logic [15:0] extOut;
  logic        accept;

  assign ext_place = (imm_kind == 2'b11);
  assign ext_op    = (imm_kind == 2'b10);

  Extender uExtender (
    .in       (imm_field),
    .ExtOp    (ext_op),
    .ExtPlace (ext_place),
    .out      (extOut)
  );

  assign accept = in_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      upperReg <= 8'h00;
      immReg   <= 16'h0000;
      validReg <= 1'b0;
      usedReg  <= 1'b0;
      dropReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      upperReg <= upperNext;
      immReg   <= immNext;
      validReg <= validNext;
      usedReg  <= usedNext;
      dropReg  <= dropNext;
    end
  end

  always_comb begin
    // Defaults: hold everything, drop pulse self-clears.
    stateNext = stateReg;
    upperNext = upperReg;
    immNext   = immReg;
    validNext = validReg;
    usedNext  = usedReg;
    dropNext  = 1'b0;

    if (flush) begin
      // A prefix lost to a redirect is not a decoder error, so no drop pulse.
      stateNext = IDLE;
      upperNext = 8'h00;
      validNext = 1'b0;
      usedNext  = 1'b0;
    end else if (stall) begin
      // Hold: defaults already freeze the stage.
    end else if (!in_valid) begin
      validNext = 1'b0;
      usedNext  = 1'b0;
    end else if (is_prefix) begin
      // Prefix wins over imm_kind; a second prefix displaces the first.
      upperNext = imm_field;
      stateNext = PREFIXED;
      validNext = 1'b0;
      usedNext  = 1'b0;
      dropNext  = (stateReg == PREFIXED);
    end else if (imm_kind != 2'b00) begin
      validNext = 1'b1;
      if (stateReg == PREFIXED) begin
        // Prefixed constant: kind's width and signedness do not apply.
        immNext   = {upperReg, imm_field};
        usedNext  = 1'b1;
        stateNext = IDLE;
      end else begin
        immNext  = extOut;
        usedNext = 1'b0;
      end
    end else begin
      validNext = 1'b0;
      usedNext  = 1'b0;
      dropNext  = (stateReg == PREFIXED);
      stateNext = IDLE;
    end
  end

  assign imm_q          = immReg;
  assign imm_valid_q    = validReg;
  assign prefix_used_q  = usedReg;
  assign prefix_pending = (stateReg == PREFIXED);
  assign prefix_drop    = dropReg;

  // accept is the qualifying condition for the decode branches above.
  logic unusedAccept;
  assign unusedAccept = accept;
endmodule

// File: tb/tb_imm_ctrl.sv
// Directed bench for imm_ctrl: linear sequence of steps, immediate assertions.
module tb_imm_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  imm_field;
  logic [1:0]  imm_kind;
  logic        is_prefix;
  logic        stall;
  logic        flush;
  logic        ext_op;
  logic        ext_place;
  logic [15:0] imm_q;
  logic        imm_valid_q;
  logic        prefix_used_q;
  logic        prefix_pending;
  logic        prefix_drop;

  int checks = 0;
  int failures = 0;

  imm_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .imm_field      (imm_field),
    .imm_kind       (imm_kind),
    .is_prefix      (is_prefix),
    .stall          (stall),
    .flush          (flush),
    .ext_op         (ext_op),
    .ext_place      (ext_place),
    .imm_q          (imm_q),
    .imm_valid_q    (imm_valid_q),
    .prefix_used_q  (prefix_used_q),
    .prefix_pending (prefix_pending),
    .prefix_drop    (prefix_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full registered output set in one go.
  task automatic chkAll(input string tag, input logic [15:0] eImm, input logic eValid,
                        input logic eUsed, input logic ePend, input logic eDrop);
    chk({tag, ".imm_q"}, imm_q, eImm);
    chk({tag, ".imm_valid_q"}, {15'b0, imm_valid_q}, {15'b0, eValid});
    chk({tag, ".prefix_used_q"}, {15'b0, prefix_used_q}, {15'b0, eUsed});
    chk({tag, ".prefix_pending"}, {15'b0, prefix_pending}, {15'b0, ePend});
    chk({tag, ".prefix_drop"}, {15'b0, prefix_drop}, {15'b0, eDrop});
    $display("step %-10s imm_q=%h valid=%b used=%b pending=%b drop=%b",
             tag, imm_q, imm_valid_q, prefix_used_q, prefix_pending, prefix_drop);
  endtask

  task automatic drive(input logic v, input logic p, input logic [1:0] k, input logic [7:0] f,
                       input logic s, input logic fl);
    in_valid = v; is_prefix = p; imm_kind = k; imm_field = f; stall = s; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 8'hAA, 1'b0, 1'b0);
    #1;

    // Reset held two cycles while a prefix is offered.
    cyc(); chkAll("rst1", 16'h0000, 0, 0, 0, 0);
    cyc(); chkAll("rst2", 16'h0000, 0, 0, 0, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    cyc(); chkAll("rst_after", 16'h0000, 0, 0, 0, 0);

    // Extension modes.
    drive(1'b1, 1'b0, 2'b10, 8'h1C, 1'b0, 1'b0);
    #1;
    chk("ext_op_k10", {15'b0, ext_op}, 16'h0001);
    chk("ext_place_k10", {15'b0, ext_place}, 16'h0000);
    cyc(); chkAll("sx5", 16'hFFFC, 1, 0, 0, 0);

    drive(1'b1, 1'b0, 2'b01, 8'h1C, 1'b0, 1'b0);
    #1;
    chk("ext_op_k01", {15'b0, ext_op}, 16'h0000);
    cyc(); chkAll("zx5", 16'h001C, 1, 0, 0, 0);

    drive(1'b1, 1'b0, 2'b11, 8'h80, 1'b0, 1'b0);
    #1;
    chk("ext_place_k11", {15'b0, ext_place}, 16'h0001);
    chk("ext_op_k11", {15'b0, ext_op}, 16'h0000);
    cyc(); chkAll("zx8", 16'h0080, 1, 0, 0, 0);

    // Bits 7:5 ignored for imm5 kinds.
    drive(1'b1, 1'b0, 2'b10, 8'hE3, 1'b0, 1'b0);
    cyc(); chkAll("sx5_hi", 16'h0003, 1, 0, 0, 0);

    // Bubble: valid and used clear, imm_q holds.
    drive(1'b0, 1'b0, 2'b01, 8'h55, 1'b0, 1'b0);
    cyc(); chkAll("bubble", 16'h0003, 0, 0, 0, 0);

    // Prefix merge.
    drive(1'b1, 1'b1, 2'b00, 8'hAB, 1'b0, 1'b0);
    cyc(); chkAll("pfx_AB", 16'h0003, 0, 0, 1, 0);
    drive(1'b1, 1'b0, 2'b01, 8'hCD, 1'b0, 1'b0);
    cyc(); chkAll("merge_ABCD", 16'hABCD, 1, 1, 0, 0);
    drive(1'b1, 1'b0, 2'b10, 8'h1F, 1'b0, 1'b0);
    cyc(); chkAll("after_merge", 16'hFFFF, 1, 0, 0, 0);

    // Stall between prefix and consumer.
    drive(1'b1, 1'b1, 2'b00, 8'h12, 1'b0, 1'b0);
    cyc(); chkAll("pfx_12", 16'hFFFF, 0, 0, 1, 0);
    drive(1'b1, 1'b0, 2'b11, 8'h34, 1'b1, 1'b0);
    cyc(); chkAll("stall1", 16'hFFFF, 0, 0, 1, 0);
    cyc(); chkAll("stall2", 16'hFFFF, 0, 0, 1, 0);
    cyc(); chkAll("stall3", 16'hFFFF, 0, 0, 1, 0);
    drive(1'b1, 1'b0, 2'b11, 8'h34, 1'b0, 1'b0);
    cyc(); chkAll("merge_1234", 16'h1234, 1, 1, 0, 0);

    // Stall holds a valid result too.
    drive(1'b1, 1'b0, 2'b01, 8'h07, 1'b1, 1'b0);
    cyc(); chkAll("stall_hold", 16'h1234, 1, 1, 0, 0);

    // Prefix followed by a non-immediate instruction: one drop pulse.
    drive(1'b1, 1'b1, 2'b00, 8'h55, 1'b0, 1'b0);
    cyc(); chkAll("pfx_55", 16'h1234, 0, 0, 1, 0);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    cyc(); chkAll("drop_k00", 16'h1234, 0, 0, 0, 1);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    cyc(); chkAll("drop_end", 16'h1234, 0, 0, 0, 0);

    // Double prefix: second replaces first with one drop pulse.
    drive(1'b1, 1'b1, 2'b00, 8'h11, 1'b0, 1'b0);
    cyc(); chkAll("pfx_11", 16'h1234, 0, 0, 1, 0);
    drive(1'b1, 1'b1, 2'b00, 8'h22, 1'b0, 1'b0);
    cyc(); chkAll("pfx_22", 16'h1234, 0, 0, 1, 1);
    drive(1'b1, 1'b0, 2'b01, 8'h00, 1'b0, 1'b0);
    cyc(); chkAll("merge_2200", 16'h2200, 1, 1, 0, 0);

    // Flush (with stall) kills a pending prefix, no drop pulse.
    drive(1'b1, 1'b1, 2'b00, 8'h77, 1'b0, 1'b0);
    cyc(); chkAll("pfx_77", 16'h2200, 0, 0, 1, 0);
    drive(1'b1, 1'b0, 2'b10, 8'h05, 1'b1, 1'b1);
    cyc(); chkAll("flush", 16'h2200, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 2'b10, 8'h10, 1'b0, 1'b0);
    cyc(); chkAll("post_flush", 16'hFFF0, 1, 0, 0, 0);

    // Reset in the middle of a prefix: discarded, no drop pulse.
    drive(1'b1, 1'b1, 2'b00, 8'h99, 1'b0, 1'b0);
    cyc(); chkAll("pfx_99", 16'hFFF0, 0, 0, 1, 0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'b01, 8'h01, 1'b1, 1'b0);
    cyc(); chkAll("rst_mid", 16'h0000, 0, 0, 0, 0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0);
    cyc(); chkAll("rst_mid_nx", 16'h0001, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
